// File: rtl/process_step_scheduler.sv
// process_step_scheduler
// Round-robin, single-threaded process sequencer for the execution interface.
// It runs one init round at step -1, then numbered steps 0,1,2... and asks for
// a trace dump after each one. The run stops on any processStop or when the
// step budget runs out, and a return code reports which of the two it was.
// Optional build macro: PROCESS_STEP_SCHEDULER_TRACE_HANDSHAKE_EN
//   defined   -> TRACE holds until traceAck is sampled high
//   undefined -> TRACE lasts exactly one cycle and traceAck is ignored
module process_step_scheduler #(
  parameter int N_PROCESSES = 4,
  parameter int STEP_WIDTH  = 32,
  parameter int CUR_WIDTH   = 2
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   start,
  input  logic [STEP_WIDTH-1:0]  maxSteps,
  input  logic [N_PROCESSES-1:0] processStop,
  output logic                   processInit,
  output logic [N_PROCESSES-1:0] processEnable,
  output logic [CUR_WIDTH-1:0]   processCurrent,
  output logic [STEP_WIDTH-1:0]  step,
  output logic                   traceReq,
  input  logic                   traceAck,
  output logic                   running,
  output logic                   done,
  output logic [1:0]             returnCode
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_TRACE,
    S_DONE
  } state_t;

  localparam logic [CUR_WIDTH-1:0]   LAST_K    = CUR_WIDTH'(N_PROCESSES - 1);
  localparam logic [N_PROCESSES-1:0] FIRST_ENA = N_PROCESSES'(1);

  state_t                   r_state;
  logic [STEP_WIDTH-1:0]    r_max_steps;
  logic [CUR_WIDTH-1:0]     r_k;
  logic                     r_init;
  logic [N_PROCESSES-1:0]   r_enable;
  logic [CUR_WIDTH-1:0]     r_cur;
  logic [STEP_WIDTH-1:0]    r_step;
  logic                     r_trace_req;
  logic                     r_running;
  logic                     r_done;
  logic [1:0]               r_rc;

  logic                     w_stop_any;
  logic                     w_start_ok;
  logic [STEP_WIDTH-1:0]    w_s;
  logic                     w_continue;
  logic                     w_last_k;
  logic [CUR_WIDTH-1:0]     w_k_inc;
  logic [N_PROCESSES-1:0]   w_onehot_next;
  logic                     w_trace_leave;

  assign w_stop_any = |processStop;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Candidate step at a continuation point: 0 after INIT, step+1 after TRACE.
  assign w_s        = (r_state == S_INIT) ? '0 : r_step + STEP_WIDTH'(1);
  assign w_continue = ($signed(w_s) < $signed(r_max_steps)) && !w_stop_any;

  assign w_last_k   = (r_k == LAST_K);
  assign w_k_inc    = r_k + CUR_WIDTH'(1);

  // One-hot decode of the next process index within a round.
  genvar gi;
  generate
    for (gi = 0; gi < N_PROCESSES; gi++) begin : g_onehot
      assign w_onehot_next[gi] = (w_k_inc == CUR_WIDTH'(gi));
    end
  endgenerate

`ifdef PROCESS_STEP_SCHEDULER_TRACE_HANDSHAKE_EN
  assign w_trace_leave = traceAck;
`else
  // Without the handshake the dump request is a fixed one-cycle pulse.
  logic w_unused_trace_ack;
  assign w_unused_trace_ack = traceAck;
  assign w_trace_leave      = 1'b1;
`endif

  // Scheduler FSM; every output is registered and updated with the state.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_max_steps <= '0;
      r_k         <= '0;
      r_init      <= 1'b0;
      r_enable    <= '0;
      r_cur       <= '0;
      r_step      <= '1;
      r_trace_req <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_rc        <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_max_steps <= maxSteps;
            r_step      <= '1;
            r_state     <= S_INIT;
            r_init      <= 1'b1;
            r_enable    <= '1;
            r_cur       <= '0;
            r_running   <= 1'b1;
            r_done      <= 1'b0;
            r_rc        <= 2'd0;
          end
        end
        S_INIT: begin
          r_init <= 1'b0;
          r_k    <= '0;
          r_step <= w_s;
          if (w_continue) begin
            r_state  <= S_RUN;
            r_enable <= FIRST_ENA;
            r_cur    <= '0;
          end else begin
            r_state   <= S_DONE;
            r_enable  <= '0;
            r_cur     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_rc      <= w_stop_any ? 2'd0 : 2'd1;
          end
        end
        S_RUN: begin
          // The round always completes; stop is only looked at afterwards.
          if (w_last_k) begin
            r_state     <= S_TRACE;
            r_enable    <= '0;
            r_cur       <= '0;
            r_trace_req <= 1'b1;
          end else begin
            r_k      <= w_k_inc;
            r_enable <= w_onehot_next;
            r_cur    <= w_k_inc;
          end
        end
        S_TRACE: begin
          if (w_trace_leave) begin
            r_trace_req <= 1'b0;
            r_step      <= w_s;
            r_k         <= '0;
            if (w_continue) begin
              r_state  <= S_RUN;
              r_enable <= FIRST_ENA;
              r_cur    <= '0;
            end else begin
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
              r_rc      <= w_stop_any ? 2'd0 : 2'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign processInit    = r_init;
  assign processEnable  = r_enable;
  assign processCurrent = r_cur;
  assign step           = r_step;
  assign traceReq       = r_trace_req;
  assign running        = r_running;
  assign done           = r_done;
  assign returnCode     = r_rc;

endmodule
